// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
    parameter int ALUOP_W = 2
);
    logic [5:0]         op;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               retire;
    logic               illegal;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, pc_source,
        output i_or_d, mem_read, mem_write, ir_write,
        output mem_to_reg, reg_dst, reg_write,
        output alu_src_a, alu_src_b, alu_op,
        output retire, illegal
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, pc_source,
        input  i_or_d, mem_read, mem_write, ir_write,
        input  mem_to_reg, reg_dst, reg_write,
        input  alu_src_a, alu_src_b, alu_op,
        input  retire, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset main control FSM.
// Sequences shared memory, ALU and register file; unknown opcodes trap.
module multicycle_control #(
    parameter int         ALUOP_W  = 2,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master ctl
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADDR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC,
        S_RWB,
        S_ADDI_EX,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

    state_t state_q;
    state_t state_d;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_addi;
    logic is_beq;
    logic is_j;

    assign is_lw   = (ctl.op == OP_LW);
    assign is_sw   = (ctl.op == OP_SW);
    assign is_r    = (ctl.op == OP_RTYPE);
    assign is_addi = (ctl.op == OP_ADDI);
    assign is_beq  = (ctl.op == OP_BEQ);
    assign is_j    = (ctl.op == OP_J);

    // State register; reset drops any access in flight and restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; outputs silenced while reset is held.
    always_comb begin
        state_d           = state_q;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.pc_source     = 2'd0;
        ctl.i_or_d        = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = 2'd0;
        ctl.alu_op        = ALU_ADD;
        ctl.retire        = 1'b0;
        ctl.illegal       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                ctl.pc_write  = ctl.mem_ready;
                ctl.ir_write  = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'd3;
                unique case (1'b1)
                    is_lw, is_sw: state_d = S_MEMADDR;
                    is_r:         state_d = S_EXEC;
                    is_addi:      state_d = S_ADDI_EX;
                    is_beq:       state_d = S_BRANCH;
                    is_j:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (ctl.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.retire     = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                ctl.retire    = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FN;
                state_d = S_RWB;
            end
            S_RWB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                ctl.retire    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'd1;
                ctl.retire        = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'd2;
                ctl.retire    = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                ctl.illegal = 1'b1;
            end
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase

        if (!rst_n) begin
            ctl.pc_write      = 1'b0;
            ctl.pc_write_cond = 1'b0;
            ctl.pc_source     = 2'd0;
            ctl.i_or_d        = 1'b0;
            ctl.mem_read      = 1'b0;
            ctl.mem_write     = 1'b0;
            ctl.ir_write      = 1'b0;
            ctl.mem_to_reg    = 1'b0;
            ctl.reg_dst       = 1'b0;
            ctl.reg_write     = 1'b0;
            ctl.alu_src_a     = 1'b0;
            ctl.alu_src_b     = 2'd0;
            ctl.alu_op        = ALU_ADD;
            ctl.retire        = 1'b0;
            ctl.illegal       = 1'b0;
        end
    end

endmodule
